div_sched: RTL
==============

// Module: div_sched
// PURPOSE
// Sequences the two shared divider IPs (signed, unsigned) on behalf of the EX stage for div.w/mod.w/div.wu/mod.wu.
// - Accepts one request at a time and drives the selected IP's AXI-stream operand handshake.
// - Captures the 64-bit IP result in the single cycle it is valid, since the IPs have no dout backpressure.
// - Holds the selected half until EX consumes it.
// - On flush, cancels the op and silently drains any result still in flight, so a stale quotient can never reach a later instruction.
// PARAMETERS
// W  32  operand width; IP dout is 2*W bits, {quotient, remainder}
// PORTS
// clk          in   1    clock
// rst          in   1    synchronous, active-high reset
// flush        in   1    pipeline flush (exception/ertn); cancels current op
// req_valid    in   1    EX presents a divide op
// req_ready    out  1    block can accept a request
// req_signed   in   1    1 = signed IP, 0 = unsigned IP
// req_mod      in   1    1 = return remainder, 0 = return quotient
// req_src1     in   W    dividend
// req_src2     in   W    divisor
// resp_valid   out  1    result available
// resp_ready   in   1    EX accepts result (readygo & MEM_allowin)
// resp_data    out  W    quotient or remainder
// sdiv_tvalid  out  1    signed IP dividend/divisor tvalid (shared)
// sdiv_tready  in   1    AND of signed IP dividend/divisor tready
// udiv_tvalid  out  1    unsigned IP tvalid
// udiv_tready  in   1    AND of unsigned IP treadys
// div_dividend out  W    operand to both IPs (registered)
// div_divisor  out  W    operand to both IPs (registered)
// sdiv_dout_v  in   1    signed IP m_axis_dout_tvalid
// sdiv_dout    in   2W   signed IP result
// udiv_dout_v  in   1    unsigned IP m_axis_dout_tvalid
// udiv_dout    in   2W   unsigned IP result
// BEHAVIOUR
// - Reset: state IDLE, kill=0; all outputs 0 except req_ready=1.
// - States and transitions:
//   - IDLE: req_ready=1. If req_valid & ~flush: latch src1/src2/signed/mod, go to ISSUE. If flush is high in the same cycle, the request is dropped.
//   - ISSUE: raise tvalid of the selected IP only; operands held stable. On tvalid & tready go to WAIT.
//     - Flush here sets kill. tvalid stays up until the handshake completes (no AXI tvalid retraction); then go to WAIT.
//   - WAIT: tvalid=0. On dout_v of the selected IP, go to DONE, capturing dout[2W-1:W] (req_mod=0) or dout[W-1:0] (req_mod=1) into resp_data.
//     - Flush here sets kill. If kill is set (including a flush in the same cycle as dout_v), discard the result, clear kill and go to IDLE.
//   - DONE: resp_valid=1, resp_data held. On resp_ready go to IDLE. Flush in DONE goes to IDLE with resp_valid=0 next cycle.
//   - resp_ready and flush in the same cycle: flush wins.
// - Timing:
//   - resp_valid rises exactly 1 cycle after dout_v is sampled in WAIT.
//   - Accept to tvalid: 1 cycle.
//   - A new request can be accepted the cycle after the resp_ready handshake.
// - dout_v from the non-selected IP, or any dout_v outside WAIT, is ignored.
// - Divide-by-zero: IP result passed through unchanged (architecturally undefined).
// - rst mid-op goes to IDLE immediately; the top level resets both IPs with the same rst.
// - resp_valid never asserts for a killed op.
// TESTING
// 1. signed, src1=0xFFFFFFF9 (-7), src2=2, mod=0 -> resp_data=0xFFFFFFFD; mod=1 -> 0xFFFFFFFF.
// 2. unsigned, src1=0xFFFFFFFF, src2=2, mod=0 -> 0x7FFFFFFF; sdiv_tvalid stays 0.
// 3. sdiv_tready held 0 for 3 cycles -> sdiv_tvalid=1 and operands unchanged all 3 cycles; WAIT entered the cycle after tready=1.
// 4. flush 2 cycles into WAIT, then next req 100/7 unsigned -> no resp_valid for the killed op; req_ready=0 until the old dout_v; then resp_data=14.
// 5. DONE with resp_ready=0 for 4 cycles -> resp_valid/resp_data stable; then flush -> resp_valid=0 next cycle, req_ready=1.
// 6. rst asserted in WAIT -> next cycle req_ready=1, resp_valid=0, tvalids=0; stray dout_v in IDLE ignored.

Source files
------------

// File: rtl/div_sched.sv
// Divider scheduler: sequences the signed/unsigned divider IPs for EX.
// One op in flight; results for flushed ops are drained and dropped.
module div_sched #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_signed,
  input  logic           req_mod,
  input  logic [W-1:0]   req_src1,
  input  logic [W-1:0]   req_src2,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [W-1:0]   resp_data,
  output logic           sdiv_tvalid,
  input  logic           sdiv_tready,
  output logic           udiv_tvalid,
  input  logic           udiv_tready,
  output logic [W-1:0]   div_dividend,
  output logic [W-1:0]   div_divisor,
  input  logic           sdiv_dout_v,
  input  logic [2*W-1:0] sdiv_dout,
  input  logic           udiv_dout_v,
  input  logic [2*W-1:0] udiv_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic           kill_q, kill_d;
  logic           sgn_q, sgn_d;
  logic           mod_q, mod_d;
  logic [W-1:0]   src1_q, src1_d;
  logic [W-1:0]   src2_q, src2_d;
  logic [W-1:0]   data_q, data_d;

  logic           hs;
  logic           dv;
  logic [2*W-1:0] dout_sel;

  // Only the IP chosen at accept time is ever observed.
  assign hs       = sgn_q ? sdiv_tready : udiv_tready;
  assign dv       = sgn_q ? sdiv_dout_v : udiv_dout_v;
  assign dout_sel = sgn_q ? sdiv_dout   : udiv_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      sgn_q   <= 1'b0;
      mod_q   <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      sgn_q   <= sgn_d;
      mod_q   <= mod_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    sgn_d   = sgn_q;
    mod_d   = mod_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          sgn_d   = req_signed;
          mod_d   = req_mod;
          src1_d  = req_src1;
          src2_d  = req_src2;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // tvalid is never retracted; a flush only marks the op dead.
        if (flush) kill_d = 1'b1;
        if (hs) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dv) begin
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            data_d  = mod_q ? dout_sel[W-1:0] : dout_sel[2*W-1:W];
            state_d = S_DONE;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_DONE);
  assign resp_data    = data_q;
  assign sdiv_tvalid  = (state_q == S_ISSUE) && sgn_q;
  assign udiv_tvalid  = (state_q == S_ISSUE) && !sgn_q;
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;

endmodule
